// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus burst-framed output stream for fifo_burst_reader.
// master = the reader block, slave = the FIFO/consumer side.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic             empty;
    logic [OW-1:0]    occup;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        input  empty, occup, rd_data, out_ready,
        output rd_en, out_valid, out_data, out_last, busy
    );

    modport slave (
        output empty, occup, rd_data, out_ready,
        input  rd_en, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side controller for a fall-through FIFO: pops words into bursts of BURST_LEN,
// or flushes a partial FIFO after TIMEOUT idle cycles. FIFO_BURST_READER_STATS_EN adds counters.
module fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_reader_if.master bus
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]         stat_words,
    output logic [15:0]         stat_bursts,
    output logic [15:0]         stat_flushes
`endif
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [OW-1:0] BURST_CNT  = OW'(BURST_LEN);
    localparam logic [OW-1:0] CNT_ONE    = OW'(1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_r;
    logic [OW-1:0]    cnt_r;
    logic [TW-1:0]    timer_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic             busy_r;

    logic can_load_s;
    logic pop_s;
    logic burst_go_s;
    logic flush_go_s;

    // Pop qualification and IDLE entry decisions; a full burst wins over the flush timeout
    always_comb begin
        can_load_s = !out_valid_r || bus.out_ready;
        pop_s      = (state_r != ST_IDLE) && !bus.empty && can_load_s && (cnt_r != {OW{1'b0}});
        burst_go_s = (state_r == ST_IDLE) && (bus.occup >= BURST_CNT);
        flush_go_s = (state_r == ST_IDLE) && !burst_go_s && (TIMEOUT != 0) &&
                     !bus.empty && (timer_r == TIMER_LAST);
    end

    assign bus.rd_en     = pop_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;

    // Sequencer and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {OW{1'b0}};
            timer_r     <= {TW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                out_data_r  <= bus.rd_data;
                out_valid_r <= 1'b1;
                out_last_r  <= (cnt_r == CNT_ONE);
                cnt_r       <= cnt_r - CNT_ONE;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (burst_go_s) begin
                        state_r <= ST_BURST;
                        cnt_r   <= BURST_CNT;
                        timer_r <= {TW{1'b0}};
                        busy_r  <= 1'b1;
                    end else if (flush_go_s) begin
                        state_r <= ST_FLUSH;
                        cnt_r   <= bus.occup;
                        timer_r <= {TW{1'b0}};
                        busy_r  <= 1'b1;
                    end else if (bus.empty || (TIMEOUT == 0)) begin
                        timer_r <= {TW{1'b0}};
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_BURST, ST_FLUSH: begin
                    if (pop_s && (cnt_r == CNT_ONE)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        if (en && (value != 16'hFFFF)) begin
            return value + 16'd1;
        end else begin
            return value;
        end
    endfunction

    // Saturating activity counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words   <= 16'd0;
            stat_bursts  <= 16'd0;
            stat_flushes <= 16'd0;
        end else begin
            stat_words   <= sat_inc(stat_words, pop_s);
            stat_bursts  <= sat_inc(stat_bursts, burst_go_s);
            stat_flushes <= sat_inc(stat_flushes, flush_go_s);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and a
// framing model (full bursts then one flush of the remainder) predicts the output stream.
module tb_fifo_burst_reader;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 64;
    localparam int OW        = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic             ready_v = 1'b0;

    logic             o_rd;
    logic             o_valid;
    logic             o_last;
    logic             o_busy;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;

    fifo_burst_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_bursts;
    logic [15:0] stat_flushes;
`endif

    fifo_burst_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef FIFO_BURST_READER_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_bursts(stat_bursts),
        .stat_flushes(stat_flushes)
`endif
    );

    always #5 clk = ~clk;

    // One clock: present the FIFO model at negedge, sample, then apply the pop after posedge.
    task automatic cycle();
        int sz;
        @(negedge clk);
        sz            = fifo_q.size();
        bus.empty     = (sz == 0);
        bus.occup     = OW'(sz);
        bus.rd_data   = (sz != 0) ? fifo_q[0] : {WIDTH{1'b0}};
        bus.out_ready = ready_v;
        #1;
        o_rd    = bus.rd_en;
        o_valid = bus.out_valid;
        o_data  = bus.out_data;
        o_last  = bus.out_last;
        o_busy  = bus.busy;
        o_ready = bus.out_ready;
        @(posedge clk);
        #1;
        if (o_rd && rst_n && (fifo_q.size() != 0)) begin
            void'(fifo_q.pop_front());
        end
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(WIDTH'($urandom));
        end
    endtask

    // Drain whatever the FIFO model holds and compare the stream against the framing model.
    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic test_drain(input int mode, input string tag);
        logic [WIDTH-1:0] exp_d[$];
        int n, full, beats, pops, cyc, first_pop, last_beat_cyc, limit, exp_first;
        logic pv, pr, pl, prev_was_last, exp_last;
        logic [WIDTH-1:0] pd;
        exp_d = fifo_q;
        n     = exp_d.size();
        full  = (n / BURST_LEN) * BURST_LEN;
        beats = 0; pops = 0; cyc = 0; first_pop = -1; last_beat_cyc = -10;
        limit = n * 8 + TIMEOUT + 50;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = {WIDTH{1'b0}}; prev_was_last = 1'b1;
        while ((beats < n) && (cyc < limit)) begin
            case (mode)
                0:       ready_v = 1'b1;
                1:       ready_v = ((cyc % 3) == 0);
                default: ready_v = 1'($urandom_range(0, 1));
            endcase
            cycle();
            if (o_rd) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
            end
            if (pv && !pr) begin
                checks++;
                if ((o_valid !== 1'b1) || (o_data !== pd) || (o_last !== pl)) begin
                    failures++;
                    $display("FAIL %s_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             tag, cyc, o_valid, o_data, o_last, pd, pl);
                end
            end
            if (o_valid && !o_ready) begin
                checks++;
                if (o_rd !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_stall_pop cyc=%0d got rd_en=%b want 0", tag, cyc, o_rd);
                end
            end
            if (o_valid && o_ready) begin
                exp_last = (beats < full) ? ((beats % BURST_LEN) == (BURST_LEN - 1)) : (beats == n - 1);
                checks++;
                if (o_data !== exp_d[beats]) begin
                    failures++;
                    $display("FAIL %s_data beat=%0d got %h want %h", tag, beats, o_data, exp_d[beats]);
                end
                checks++;
                if (o_last !== exp_last) begin
                    failures++;
                    $display("FAIL %s_last beat=%0d got %b want %b", tag, beats, o_last, exp_last);
                end
                if (!exp_last) begin
                    checks++;
                    if (o_busy !== 1'b1) begin
                        failures++;
                        $display("FAIL %s_busy_mid beat=%0d got %b want 1", tag, beats, o_busy);
                    end
                end
                if (mode == 0) begin
                    if (!prev_was_last) begin
                        checks++;
                        if (cyc != last_beat_cyc + 1) begin
                            failures++;
                            $display("FAIL %s_b2b beat=%0d got cyc=%0d want %0d", tag, beats, cyc, last_beat_cyc + 1);
                        end
                    end
                    if (exp_last) begin
                        checks++;
                        if (o_busy !== 1'b0) begin
                            failures++;
                            $display("FAIL %s_busy_end beat=%0d got %b want 0", tag, beats, o_busy);
                        end
                    end
                end
                prev_was_last = exp_last;
                last_beat_cyc = cyc;
                beats++;
            end
            pv = o_valid; pr = o_ready; pd = o_data; pl = o_last;
            cyc++;
        end
        checks++;
        if (beats != n) begin
            failures++;
            $display("FAIL %s_beats got %0d want %0d (cycle budget %0d)", tag, beats, n, limit);
        end
        checks++;
        if (pops != n) begin
            failures++;
            $display("FAIL %s_pops got %0d want %0d", tag, pops, n);
        end
        if (n > 0) begin
            exp_first = (n >= BURST_LEN) ? 1 : TIMEOUT;
            checks++;
            if (first_pop != exp_first) begin
                failures++;
                $display("FAIL %s_first_pop got cyc=%0d want %0d", tag, first_pop, exp_first);
            end
        end
        ready_v = 1'b1;
        repeat (3) cycle();
        checks++;
        if ((o_valid !== 1'b0) || (o_busy !== 1'b0) || (o_rd !== 1'b0)) begin
            failures++;
            $display("FAIL %s_idle got v=%b busy=%b rd=%b want 0 0 0", tag, o_valid, o_busy, o_rd);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ready_v = 1'b1;
        push_random(3);
        repeat (3) cycle();
        checks++;
        if ((o_rd !== 1'b0) || (o_valid !== 1'b0) || (o_data !== {WIDTH{1'b0}}) ||
            (o_last !== 1'b0) || (o_busy !== 1'b0)) begin
            failures++;
            $display("FAIL reset_outputs got rd=%b v=%b d=%h l=%b busy=%b want all 0",
                     o_rd, o_valid, o_data, o_last, o_busy);
        end
        rst_n = 1'b1;
        test_drain(0, "reset_flush");
    endtask

    task automatic test_reset_mid_burst();
        logic [WIDTH-1:0] exp_d[$];
        int beats, cyc;
        push_random(8);
        exp_d   = fifo_q;
        ready_v = 1'b1;
        beats   = 0;
        cyc     = 0;
        while ((beats < 2) && (cyc < 20)) begin
            cycle();
            if (o_valid && o_ready) begin
                checks++;
                if (o_data !== exp_d[beats]) begin
                    failures++;
                    $display("FAIL midrst_data beat=%0d got %h want %h", beats, o_data, exp_d[beats]);
                end
                beats++;
            end
            cyc++;
        end
        checks++;
        if (beats != 2) begin
            failures++;
            $display("FAIL midrst_beats got %0d want 2", beats);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ((bus.out_valid !== 1'b0) || (bus.out_data !== {WIDTH{1'b0}}) || (bus.out_last !== 1'b0) ||
            (bus.busy !== 1'b0) || (bus.rd_en !== 1'b0)) begin
            failures++;
            $display("FAIL midrst_async got v=%b d=%h l=%b busy=%b rd=%b want all 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.rd_en);
        end
        cycle();
        rst_n = 1'b1;
        checks++;
        if (fifo_q.size() != 5) begin
            failures++;
            $display("FAIL midrst_remaining got %0d words want 5", fifo_q.size());
        end
        test_drain(0, "after_rst");
    endtask

    initial begin
        bus.empty     = 1'b1;
        bus.occup     = {OW{1'b0}};
        bus.rd_data   = {WIDTH{1'b0}};
        bus.out_ready = 1'b0;

        test_reset();

        push_random(4);
        test_drain(0, "burst");

        push_random(2);
        test_drain(0, "flush");

        push_random(4);
        test_drain(1, "stall");

        push_random(9);
        test_drain(0, "nine");

        test_reset_mid_burst();

        for (int i = 0; i < 4; i++) begin
            push_random(int'($urandom_range(1, DEPTH)));
            test_drain(2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the team's fall-through FIFO.
- Watches empty/occup and pops words with rd_en.
- Presents popped words on a registered valid/ready output stream, framed into bursts with out_last.
- Sits between a FIFO read port and a burst-oriented consumer (DMA/bus master). It is the consumer counterpart of the FIFO write-side producer.

Parameters:
WIDTH, 32, data word width (matches FIFO width).
DEPTH, 16, FIFO depth; occup width is $clog2(DEPTH)+1.
BURST_LEN, 4, words per full burst; legal range 1..DEPTH.
TIMEOUT, 64, idle cycles with a partial FIFO before a flush burst; 0 disables flush.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
empty  in  1  FIFO empty; rd_data is valid when low.
occup  in  $clog2(DEPTH)+1  FIFO occupancy in words.
rd_data  in  WIDTH  FIFO head word (fall-through).
rd_en  out  1  FIFO pop strobe; combinational.
out_valid  out  1  output word valid.
out_ready  in  1  consumer accepts the word when high with out_valid.
out_data  out  WIDTH  output word.
out_last  out  1  high on the final word of a burst.
busy  out  1  high in BURST or FLUSH.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_data=0, out_last=0, busy=0; timer=0, cnt=0; rd_en=0.
- Reset mid-burst: the word held in the output register is discarded. FIFO contents are untouched.
- Output register load condition: can_load = !out_valid || out_ready.
- pop = (state!=IDLE) && !empty && can_load && cnt!=0; rd_en = pop.
- On pop: out_data<=rd_data, out_valid<=1, out_last<=(cnt==1), cnt<=cnt-1.
- Else if out_ready: out_valid<=0, out_last<=0.
- Latency: FIFO head to out_valid is 1 cycle. Throughput is 1 word/clk while out_ready=1 (no bubble on back-to-back beats).
- States:
  - IDLE:
    - occup>=BURST_LEN -> BURST, cnt<=BURST_LEN, timer<=0.
    - Else if TIMEOUT!=0 && !empty && timer==TIMEOUT-1 -> FLUSH, cnt<=occup (snapshot), timer<=0.
    - Else timer increments while !empty and clears when empty.
    - The BURST check has priority over the timeout on the same cycle.
  - BURST / FLUSH: pop per the rule above. When the pop with cnt==1 occurs -> IDLE. busy=1.
- Entry into BURST/FLUSH is registered: the first pop happens at the earliest on the cycle after the IDLE decision.
- The block is the FIFO's only reader, so the snapshot count is always available. pop is still gated by !empty so underflow is impossible.
- out_ready low stalls popping. The FIFO may fill; full is not observed by this block.
- The IDLE decision uses the current occup. Concurrent writes only add words, which are left for the next burst.
- Widths: cnt and occup are $clog2(DEPTH)+1 bits. The timer is $clog2(TIMEOUT+1) bits and never wraps because it is compared before incrementing.

Optional Feature:
FIFO_BURST_READER_STATS_EN
- Defined: adds outputs stat_words[15:0], stat_bursts[15:0] and stat_flushes[15:0].
  - stat_words increments on each pop.
  - stat_bursts increments on each BURST entry.
  - stat_flushes increments on each FLUSH entry.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset with FIFO holding 3 words: all outputs 0, rd_en 0, out_valid 0 while rst_n low, and no pop for TIMEOUT-1 cycles after release.
- Write 4 words A0..A3, out_ready=1 -> BURST; out_data A0,A1,A2,A3 on 4 consecutive cycles, out_last only on A3; busy returns to 0 after A3.
- Write 2 words, no more writes, TIMEOUT=64 -> FLUSH begins 64 cycles after the FIFO went non-empty; 2 beats, out_last on the 2nd; empty=1 afterwards.
- BURST with out_ready toggling 1,0,0,1,...: out_data/out_valid hold while stalled; exactly 4 rd_en pulses; no word lost or duplicated.
- 9 words preloaded, BURST_LEN=4: two full bursts (out_last on words 4 and 8), then the 9th word leaves as a flush of length 1 after the timeout.
- rst_n asserted mid-burst after 2 beats: outputs clear immediately (asynchronous); after release the remaining FIFO words are delivered in new bursts with correct out_last framing.
